// File: rtl/gf_barrett_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// gf_barrett_pkg : Barrett parameter helpers and standard moduli.
// Rev 1.0
// ---------------------------------------------------------------------------
package gf_barrett_pkg;

   localparam int Q_1667 = 1667;
   localparam int Q_3329 = 3329;

   function automatic int barrett_k(input int q);
      return $clog2(q);
   endfunction

   // floor(2^(2K) / Q); always fits in K+1 bits because Q > 2^(K-1).
   function automatic longint barrett_mu(input int q);
      return (longint'(1) << (2 * barrett_k(q))) / longint'(q);
   endfunction

endpackage
`default_nettype wire

// File: rtl/barrett_corr.sv
`default_nettype none
// ---------------------------------------------------------------------------
// barrett_corr : final correction, folds r in [0, 3Q) down to [0, Q).
// Rev 1.0
// ---------------------------------------------------------------------------
module barrett_corr #(
   parameter int Q = 1667,
   parameter int K = $clog2(Q)
) (
   input  logic [K+1:0] r,
   output logic [K-1:0] res
);
   localparam logic [K+1:0] Q1 = (K+2)'(Q);
   localparam logic [K+1:0] Q2 = (K+2)'(2 * Q);

   always_comb begin
      if (r >= Q2) begin
         res = K'(r - Q2);
      end else if (r >= Q1) begin
         res = K'(r - Q1);
      end else begin
         res = K'(r);
      end
   end

endmodule
`default_nettype wire

// File: rtl/barrett_reduce_pipe.sv
`default_nettype none
// ---------------------------------------------------------------------------
// barrett_reduce_pipe : 3-stage valid/ready Barrett reducer, dout_r = din_a mod Q.
// Rev 1.0
// ---------------------------------------------------------------------------
module barrett_reduce_pipe
   import gf_barrett_pkg::*;
#(
   parameter int Q     = Q_1667,
   parameter int TAG_W = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [2*$clog2(Q)-1:0] din_a,
   input  logic [TAG_W-1:0]       din_tag,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [$clog2(Q)-1:0]   dout_r,
   output logic [TAG_W-1:0]       dout_tag
);
   localparam int         K  = barrett_k(Q);
   localparam logic [K:0] MU = (K+1)'(barrett_mu(Q));

   logic             adv1, adv2, adv3;
   logic             v1_q, v2_q, v3_q;
   logic [2*K-1:0]   a_q;
   logic [2*K:0]     p1_q, p1_d;
   logic [K:0]       t_d;
   logic [K+1:0]     r_q, r_d;
   logic [K-1:0]     res_q, res_d;
   logic [TAG_W-1:0] tag1_q, tag2_q, tag3_q;

   // Bubble-collapsing advance: an empty stage always accepts.
   assign adv3     = !v3_q || out_ready;
   assign adv2     = !v2_q || adv3;
   assign adv1     = !v1_q || adv2;
   assign in_ready = adv1;

   assign p1_d = (2*K+1)'(din_a[2*K-1:K]) * (2*K+1)'(MU);
   assign t_d  = (K+1)'(p1_q >> K);
   // Low K+2 bits of the full-width difference; true value is below 3Q.
   assign r_d  = (K+2)'((2*K+2)'(a_q) - (2*K+2)'(t_d) * (2*K+2)'(Q));

   barrett_corr #(
      .Q (Q),
      .K (K)
   ) u_corr (
      .r   (r_q),
      .res (res_d)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1_q   <= 1'b0;
         v2_q   <= 1'b0;
         v3_q   <= 1'b0;
         a_q    <= '0;
         p1_q   <= '0;
         r_q    <= '0;
         res_q  <= '0;
         tag1_q <= '0;
         tag2_q <= '0;
         tag3_q <= '0;
      end else begin
         if (adv1) begin
            v1_q <= in_valid;
            if (in_valid) begin
               a_q    <= din_a;
               p1_q   <= p1_d;
               tag1_q <= din_tag;
            end
         end
         if (adv2) begin
            v2_q <= v1_q;
            if (v1_q) begin
               r_q    <= r_d;
               tag2_q <= tag1_q;
            end
         end
         if (adv3) begin
            v3_q <= v2_q;
            if (v2_q) begin
               res_q  <= res_d;
               tag3_q <= tag2_q;
            end
         end
      end
   end

   assign out_valid = v3_q;
   assign dout_r    = res_q;
   assign dout_tag  = tag3_q;

endmodule
`default_nettype wire

// File: tb/tb_barrett_reduce_pipe.sv
`default_nettype none
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_barrett_reduce_pipe : vector table, back-pressure, reset and random runs.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_barrett_reduce_pipe;
   import gf_barrett_pkg::*;

   localparam int QA = Q_1667;
   localparam int KA = barrett_k(QA);
   localparam int QB = Q_3329;
   localparam int KB = barrett_k(QB);
   localparam int TW = 4;

   typedef struct { logic [15:0] r; logic [TW-1:0] tag; int cyc; bit lat; } exp_t;
   typedef struct { logic [23:0] a; logic [TW-1:0] tag; logic [15:0] r; } vec_t;

   logic            clk = 1'b0;
   logic            rst;
   logic            in_valid, in_ready, out_valid, out_ready;
   logic [2*KA-1:0] din_a;
   logic [TW-1:0]   din_tag, dout_tag;
   logic [KA-1:0]   dout_r;
   logic            b_in_valid, b_in_ready, b_out_valid;
   logic [2*KB-1:0] b_din;
   logic [TW-1:0]   b_tag_i, b_tag_o;
   logic [KB-1:0]   b_dout;

   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   int   outs_a = 0;
   int   outs_before;
   int   ordy_pct = 100;
   bit   ordy_rand = 1'b0;
   exp_t qa[$];
   exp_t qb[$];
   vec_t tv[6];
   int   pcts[3] = '{30, 50, 90};
   logic [2*KA-1:0] ra;
   logic [2*KB-1:0] rb;
   int   idle;

   barrett_reduce_pipe #(.Q(QA), .TAG_W(TW)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .din_a(din_a), .din_tag(din_tag), .out_valid(out_valid),
      .out_ready(out_ready), .dout_r(dout_r), .dout_tag(dout_tag)
   );

   barrett_reduce_pipe #(.Q(QB), .TAG_W(TW)) dut_b (
      .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .din_a(b_din), .din_tag(b_tag_i), .out_valid(b_out_valid),
      .out_ready(1'b1), .dout_r(b_dout), .dout_tag(b_tag_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input longint got, input longint want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s got %0d want %0d", name, got, want);
      end
   endtask

   // Random out_ready generator for the density runs.
   initial forever begin
      @(posedge clk); #1;
      if (ordy_rand) out_ready = ($urandom_range(0, 99) < ordy_pct);
   end

   // Output scoreboard and stall-stability monitor for the Q=1667 instance.
   initial begin
      exp_t e;
      bit hold = 1'b0;
      logic [KA-1:0] hold_r;
      logic [TW-1:0] hold_tag;
      forever begin
         @(negedge clk);
         if (rst) begin
            qa.delete();
            hold = 1'b0;
         end else begin
            if (hold) begin
               checks++;
               if (!out_valid || dout_r != hold_r || dout_tag != hold_tag) begin
                  errors++;
                  $display("FAIL stall_stable got v=%0d r=%0d tag=%0d want v=1 r=%0d tag=%0d",
                           out_valid, dout_r, dout_tag, hold_r, hold_tag);
               end
            end
            if (out_valid && out_ready) begin
               outs_a++;
               checks++;
               if (qa.size() == 0) begin
                  errors++;
                  $display("FAIL out_a unexpected beat got r=%0d tag=%0d want none", dout_r, dout_tag);
               end else begin
                  e = qa.pop_front();
                  if (dout_r != e.r[KA-1:0] || dout_tag != e.tag) begin
                     errors++;
                     $display("FAIL out_a got r=%0d tag=%0d want r=%0d tag=%0d",
                              dout_r, dout_tag, e.r[KA-1:0], e.tag);
                  end
                  if (e.lat) chk("latency_a", cyc - e.cyc, 3);
               end
            end
            hold     = out_valid && !out_ready;
            hold_r   = dout_r;
            hold_tag = dout_tag;
         end
      end
   end

   // Output scoreboard for the Q=3329 instance (out_ready tied high).
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst) begin
            qb.delete();
         end else if (b_out_valid) begin
            checks++;
            if (qb.size() == 0) begin
               errors++;
               $display("FAIL out_b unexpected beat got r=%0d want none", b_dout);
            end else begin
               e = qb.pop_front();
               if (b_dout != e.r[KB-1:0] || b_tag_o != e.tag) begin
                  errors++;
                  $display("FAIL out_b got r=%0d tag=%0d want r=%0d tag=%0d",
                           b_dout, b_tag_o, e.r[KB-1:0], e.tag);
               end
            end
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic send(input logic [2*KA-1:0] a, input logic [TW-1:0] tag,
                       input logic [15:0] r, input bit lat, input int nidle);
      exp_t e;
      int w = 0;
      repeat (nidle) begin
         in_valid = 1'b0;
         @(posedge clk); #1;
      end
      in_valid = 1'b1;
      din_a    = a;
      din_tag  = tag;
      @(negedge clk);
      while (!in_ready && w < 500) begin
         @(negedge clk);
         w++;
      end
      if (w >= 500) begin
         checks++;
         errors++;
         $display("FAIL send_a timeout in_ready got 0 want 1");
      end else begin
         e.r = r; e.tag = tag; e.cyc = cyc; e.lat = lat;
         qa.push_back(e);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic sendb(input logic [2*KB-1:0] a, input logic [TW-1:0] tag, input logic [15:0] r);
      exp_t e;
      b_in_valid = 1'b1;
      b_din      = a;
      b_tag_i    = tag;
      @(negedge clk);
      if (!b_in_ready) begin
         checks++;
         errors++;
         $display("FAIL send_b in_ready got 0 want 1");
      end else begin
         e.r = r; e.tag = tag; e.cyc = cyc; e.lat = 1'b0;
         qb.push_back(e);
      end
      @(posedge clk); #1;
      b_in_valid = 1'b0;
   endtask

   task automatic drain_a();
      int w = 0;
      while ((qa.size() != 0 || out_valid) && w < 3000) begin
         @(negedge clk);
         w++;
      end
      if (w >= 3000) begin
         checks++;
         errors++;
         $display("FAIL drain_a timeout pending got %0d want 0", qa.size());
      end
      @(posedge clk); #1;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; din_a = '0; din_tag = '0; out_ready = 1'b1;
      b_in_valid = 1'b0; b_din = '0; b_tag_i = '0;
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_dout_r",    dout_r,    0);
      chk("rst_dout_tag",  dout_tag,  0);
      chk("rst_in_ready",  in_ready,  1);
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      @(posedge clk); #1;

      tv[0] = '{a: 24'd0,        tag: 4'd1, r: 16'd0};
      tv[1] = '{a: 24'd1666,     tag: 4'd2, r: 16'd1666};
      tv[2] = '{a: 24'd1667,     tag: 4'd3, r: 16'd0};
      tv[3] = '{a: 24'd3334,     tag: 4'd4, r: 16'd0};
      tv[4] = '{a: 24'd4194303,  tag: 4'd5, r: 16'd131};
      tv[5] = '{a: 24'd16777215, tag: 4'd9, r: 16'd2384};

      // Directed vectors, back to back with out_ready held high.
      for (int i = 0; i < 5; i++) send(tv[i].a[2*KA-1:0], tv[i].tag, tv[i].r, 1'b1, 0);
      drain_a();

      // Back-pressure: 10 beats streamed into a stalled output.
      out_ready = 1'b0;
      fork
         begin
            for (int i = 0; i < 10; i++) begin
               ra = 22'(100 * i + 7777);
               send(ra, 4'(i), 16'(ra % QA), 1'b0, 0);
            end
         end
         begin
            repeat (4) @(negedge clk);
            chk("bp_in_ready_low", in_ready, 0);
            chk("bp_out_valid",    out_valid, 1);
            chk("bp_held_beats",   qa.size(), 3);
            repeat (4) @(posedge clk);
            #1 out_ready = 1'b1;
            #1 chk("bp_in_ready_comb", in_ready, 1);
         end
      join
      drain_a();
      chk("bp_all_out", outs_a, 15);

      // Reset with three beats in flight.
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) send(22'(5000 + i), 4'(10 + i), 16'((5000 + i) % QA), 1'b0, 0);
      chk("pre_rst_out_valid", out_valid, 1);
      #2 rst = 1'b1;
      #1;
      chk("arst_out_valid", out_valid, 0);
      chk("arst_dout_r",    dout_r,    0);
      chk("arst_dout_tag",  dout_tag,  0);
      chk("arst_in_ready",  in_ready,  1);
      @(negedge clk);
      @(posedge clk);
      #2 rst = 1'b0;
      out_ready   = 1'b1;
      outs_before = outs_a;
      repeat (6) @(negedge clk);
      chk("no_stale_beat", outs_a, outs_before);
      @(posedge clk); #1;
      send(22'd3333, 4'd7, 16'd1666, 1'b1, 0);
      drain_a();

      // Random in_valid / out_ready densities.
      foreach (pcts[j]) begin
         ordy_pct  = pcts[j];
         ordy_rand = 1'b1;
         for (int i = 0; i < 150; i++) begin
            ra   = 22'($urandom);
            idle = 0;
            while ($urandom_range(0, 99) >= pcts[j] && idle < 10) idle++;
            send(ra, 4'(i), 16'(ra % QA), 1'b0, idle);
         end
         ordy_rand = 1'b0;
         @(posedge clk); #1;
         out_ready = 1'b1;
         drain_a();
      end

      // Q=3329 instance: maximum input, then random inputs.
      sendb(tv[5].a, tv[5].tag, tv[5].r);
      for (int i = 0; i < 10000; i++) begin
         rb = 24'($urandom);
         sendb(rb, 4'(i), 16'(rb % QB));
      end
      begin
         int w = 0;
         while (qb.size() != 0 && w < 100) begin
            @(negedge clk);
            w++;
         end
         chk("drain_b_pending", qb.size(), 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
